// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Only 32- and 64-bit data buses are supported.
    function automatic bit data_w_legal(input int w);
        return (w == 32) || (w == 64);
    endfunction

    // Number of byte-offset address bits dropped before register decode.
    function automatic int addr_lsb(input int w);
        return (w == 64) ? 3 : 2;
    endfunction

    // Byte-strobe merge of new write data over the current register value.
    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] cur,
        input logic [MAX_DATA_W-1:0] wdat,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        res = cur;
        for (int k = 0; k < MAX_STRB_W; k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = wdat[k*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: RW control regs, RO status regs from hw_i, write pulses, SLVERR decode.
// Latency: write commit one cycle after the later AW/W handshake, response the cycle after; read data one cycle after AR.
// Backpressure: AW/W stall while a write is held or its response is pending; AR stalls while read data is pending.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 32,
    parameter int                N_REGS  = 16,
    parameter logic [N_REGS-1:0] RO_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [ADDR_W-1:0]        s_awaddr,
    input  logic [2:0]               s_awprot,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    input  logic [DATA_W-1:0]        s_wdata,
    input  logic [DATA_W/8-1:0]      s_wstrb,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    output logic [1:0]               s_bresp,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    input  logic [ADDR_W-1:0]        s_araddr,
    input  logic [2:0]               s_arprot,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [DATA_W-1:0]        s_rdata,
    output logic [1:0]               s_rresp,
    output logic [N_REGS*DATA_W-1:0] regs_o,
    input  logic [N_REGS*DATA_W-1:0] hw_i,
    output logic [N_REGS-1:0]        wr_pulse_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = addr_lsb(DATA_W);
    localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("axil_reg_bank: DATA_W must be 32 or 64");
    end
    if (N_REGS < 1 || N_REGS > 256) begin : g_bad_n_regs
        $error("axil_reg_bank: N_REGS must be 1..256");
    end

    // Held write channel state
    logic                r_en;
    logic                r_aw_held;
    logic                r_w_held;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_bvalid;
    resp_t               r_bresp;
    logic [N_REGS-1:0]   r_wr_pulse;

    // Read channel state
    logic                r_rvalid;
    resp_t               r_rresp;
    logic [DATA_W-1:0]   r_rdata;

    // Per-register visible values (storage for RW, hw_i for RO)
    logic [DATA_W-1:0]   w_reg_val [N_REGS];

    logic                w_awready;
    logic                w_wready;
    logic                w_arready;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;

    logic [ADDR_W-1:0]   w_aw_word;
    logic                w_aw_legal;
    logic [IDX_W-1:0]    w_aw_idx;
    logic                w_aw_ro;
    logic                w_commit;
    logic                w_wr_ok;
    logic [DATA_W-1:0]   w_cur;
    logic [MAX_DATA_W-1:0] w_merge_full;
    logic [DATA_W-1:0]   w_merged;

    logic [ADDR_W-1:0]   w_ar_word;
    logic                w_ar_legal;
    logic [IDX_W-1:0]    w_ar_idx;

    logic                w_unused;

    // Ready outputs depend only on registered state, never on inputs.
    assign w_awready = r_en && !r_aw_held && !r_bvalid;
    assign w_wready  = r_en && !r_w_held  && !r_bvalid;
    assign w_arready = r_en && !r_rvalid;

    assign w_aw_hs = s_awvalid && w_awready;
    assign w_w_hs  = s_wvalid  && w_wready;
    assign w_ar_hs = s_arvalid && w_arready;

    // Write decode from the held address; any non-zero bit above the index makes it illegal.
    assign w_aw_word  = r_awaddr >> LSB;
    assign w_aw_legal = (w_aw_word < ADDR_W'(N_REGS));
    assign w_aw_idx   = w_aw_word[IDX_W-1:0];
    assign w_aw_ro    = RO_MASK[w_aw_idx];
    assign w_commit   = r_aw_held && r_w_held;
    assign w_wr_ok    = w_commit && w_aw_legal && !w_aw_ro;

    assign w_cur        = w_reg_val[w_aw_idx];
    assign w_merge_full = strb_merge(MAX_DATA_W'(w_cur), MAX_DATA_W'(r_wdata), MAX_STRB_W'(r_wstrb));
    assign w_merged     = w_merge_full[DATA_W-1:0];

    // Read decode straight from the bus address, registered on the AR handshake.
    assign w_ar_word  = s_araddr >> LSB;
    assign w_ar_legal = (w_ar_word < ADDR_W'(N_REGS));
    assign w_ar_idx   = w_ar_word[IDX_W-1:0];

    assign w_unused = ^{s_awprot, s_arprot, w_merge_full, r_awaddr, s_araddr};

    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
        if (RO_MASK[gi]) begin : g_ro
            assign w_reg_val[gi] = hw_i[gi*DATA_W +: DATA_W];
        end else begin : g_rw
            logic [DATA_W-1:0] r_val;
            logic              w_unused_hw;

            assign w_unused_hw = ^hw_i[gi*DATA_W +: DATA_W];

            // Strobe-merged update when a legal write commits to this index.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_val <= '0;
                end else if (w_wr_ok && (w_aw_idx == IDX_W'(gi))) begin
                    r_val <= w_merged;
                end
            end

            assign w_reg_val[gi] = r_val;
        end

        assign regs_o[gi*DATA_W +: DATA_W] = w_reg_val[gi];
    end

    // Write channel: independent AW/W capture, commit when both held, response until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_en       <= 1'b1;
            r_wr_pulse <= w_wr_ok ? (N_REGS'(1) << w_aw_idx) : '0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_wdata;
                r_wstrb  <= s_wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? OKAY : SLVERR;
            end else if (r_bvalid && s_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: capture data/response on AR handshake, hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            if (w_ar_legal) begin
                r_rdata <= w_reg_val[w_ar_idx];
                r_rresp <= OKAY;
            end else begin
                r_rdata <= '0;
                r_rresp <= SLVERR;
            end
        end else if (r_rvalid && s_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_awready  = w_awready;
    assign s_wready   = w_wready;
    assign s_arready  = w_arready;
    assign s_bvalid   = r_bvalid;
    assign s_bresp    = r_bresp;
    assign s_rvalid   = r_rvalid;
    assign s_rdata    = r_rdata;
    assign s_rresp    = r_rresp;
    assign wr_pulse_o = r_wr_pulse;

endmodule
